// File: rtl/serial_addsub_ovf.sv
// Bit-serial two's-complement adder/subtractor with signed-overflow detection.
// One bit is processed per clock, LSB first, through a single carry flop.
// R/C/V/Z/N are registered at completion and held until the next completion.
// A sticky overflow flag accumulates across operations until cleared.
module serial_addsub_ovf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             clr_v_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] r_o,
  output logic             c_o,
  output logic             v_o,
  output logic             z_o,
  output logic             n_o,
  output logic             sticky_v_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             carry_d;
  logic             sum_bit;
  logic             ovf_d;
  logic             last_bit;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] r_q;
  logic             c_q;
  logic             v_q;
  logic             z_q;
  logic             n_q;
  logic             sticky_q;

  // Full-adder slice on the current LSBs plus the next result shift value.
  // NOTE: combinational blocks use blocking '=' and assign every output on
  // every path, so no latch can be inferred.
  always_comb begin
    sum_bit  = a_q[0] ^ b_q[0] ^ carry_q;
    carry_d  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    res_d    = {sum_bit, res_q[WIDTH-1:1]};
    last_bit = (state_q == S_RUN) && (cnt_q == LAST);
    // While processing the MSB, carry_q is the carry into the MSB.
    ovf_d    = carry_q ^ carry_d;
  end

  // Control FSM, serial datapath and registered result/flag outputs.
  // NOTE: every register here is a plain flop (no memory arrays), so all of
  // them take the asynchronous reset; sequential updates use '<=' only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      r_q      <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            // Subtract is A + ~B + 1: invert B and seed the carry with 1.
            a_q     <= a_i;
            b_q     <= b_i ^ {WIDTH{sub_i}};
            carry_q <= sub_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_d;
          carry_q <= carry_d;
          if (cnt_q == LAST) begin
            // Final bit: publish result and flags, hold counter at the top.
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            r_q     <= res_d;
            c_q     <= carry_d;
            v_q     <= ovf_d;
            z_q     <= (res_d == '0);
            n_q     <= sum_bit;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Overflow at completion outranks a simultaneous clear request.
      if (last_bit && ovf_d) begin
        sticky_q <= 1'b1;
      end else if (clr_v_i) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign r_o        = r_q;
  assign c_o        = c_q;
  assign v_o        = v_q;
  assign z_o        = z_q;
  assign n_o        = n_q;
  assign sticky_v_o = sticky_q;

endmodule
